// File: rtl/gf7_inv_checker.sv
// gf7_inv_checker
// Bit-serial GF(2^7) multiplier that checks (operand, claimed inverse) pairs
// for f(x) = x^7+x^5+x^4+x^3+x^2+x+1 (reduction constant 7'h3F).
// Values use an 8-bit padded format; bit 7 must be 0 on input and is always
// 0 on prod.
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready
// are both high. in_ready is high only in IDLE. out_valid stays high, with
// every result field held, until an edge where out_ready is high.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   in_valid/in_ready operand pair handshake
//   a, b              operand and claimed inverse (8-bit padded)
//   out_valid/out_ready result handshake
//   prod              a*b mod f
//   is_one            prod == 1 and no format error
//   zero_in           captured a[6:0] or b[6:0] was zero
//   fmt_err           captured a[7] or b[7] was set
//   cnt_clr           synchronous clear of both tallies (wins over increment)
//   pass_cnt/fail_cnt saturating result tallies
//   dbg_state         current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module gf7_inv_checker (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] prod,
  output logic       is_one,
  output logic       zero_in,
  output logic       fmt_err,
  input  logic       cnt_clr,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] RED = 7'h3F;

  state_t     state;
  logic [6:0] op_a;
  logic [6:0] op_b;
  logic [6:0] acc;
  logic [2:0] idx;

  logic [6:0] shifted;
  logic [6:0] acc_next;
  logic       done_entry;
  logic       result_one;

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  // One MSB-first multiply step: acc*x mod f, then add A if B[idx] is set.
  always_comb begin
    shifted  = {acc[5:0], 1'b0} ^ (acc[6] ? RED : 7'h00);
    acc_next = shifted ^ (op_b[idx] ? op_a : 7'h00);
  end

  assign done_entry = (state == BUSY) && (idx == 3'd0);
  // fmt_err here is the value latched at acceptance for this pair.
  assign result_one = (acc_next == 7'h01) && !fmt_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      op_a      <= 7'h00;
      op_b      <= 7'h00;
      acc       <= 7'h00;
      idx       <= 3'd0;
      out_valid <= 1'b0;
      prod      <= 8'h00;
      is_one    <= 1'b0;
      zero_in   <= 1'b0;
      fmt_err   <= 1'b0;
      pass_cnt  <= 8'h00;
      fail_cnt  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a    <= a[6:0];
            op_b    <= b[6:0];
            zero_in <= (a[6:0] == 7'h00) || (b[6:0] == 7'h00);
            fmt_err <= a[7] || b[7];
            acc     <= 7'h00;
            idx     <= 3'd6;
            state   <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          if (idx == 3'd0) begin
            prod      <= {1'b0, acc_next};
            is_one    <= result_one;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Tallies: a clear on the same edge as a result discards that count.
      if (cnt_clr) begin
        pass_cnt <= 8'h00;
        fail_cnt <= 8'h00;
      end else if (done_entry) begin
        if (result_one) begin
          if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'h01;
        end else begin
          if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'h01;
        end
      end
    end
  end

endmodule

// File: tb/tb_gf7_inv_checker.sv
// Testbench for gf7_inv_checker: directed pairs checked against a polynomial
// multiply-and-reduce model plus hand-computed literals.
module tb_gf7_inv_checker;

  localparam int EW = 27; // {prod[8], is_one, zero_in, fmt_err, pass[8], fail[8]}

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] prod;
  logic       is_one;
  logic       zero_in;
  logic       fmt_err;
  logic       cnt_clr;
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int m_pass = 0;
  int m_fail = 0;

  gf7_inv_checker dut (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .prod(prod), .is_one(is_one), .zero_in(zero_in), .fmt_err(fmt_err),
    .cnt_clr(cnt_clr), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // Full polynomial product, then reduce from the top using f = 0xBF.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [12:0] p;
    p = '0;
    for (int k = 0; k < 7; k++)
      if (y[k]) p = p ^ (13'(x[6:0]) << k);
    for (int k = 12; k >= 7; k--)
      if (p[k]) p = p ^ (13'h0BF << (k - 7));
    return {1'b0, p[6:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("prod",     prod,     exp_q[0][26:19]);
        chk("is_one",   is_one,   exp_q[0][18]);
        chk("zero_in",  zero_in,  exp_q[0][17]);
        chk("fmt_err",  fmt_err,  exp_q[0][16]);
        chk("pass_cnt", pass_cnt, exp_q[0][15:8]);
        chk("fail_cnt", fail_cnt, exp_q[0][7:0]);
        chk("in_ready_done", in_ready, 0);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && exp_q.size() > 0)
      void'(exp_q.pop_front());
  end

  // ---------------- driver ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_pass = 0;
    m_fail = 0;
  endtask

  // Send one pair; hold out_ready low for 'hold' DONE cycles (with a stray
  // in_valid), optionally pulse cnt_clr on the DONE-entry edge.
  task automatic send(input logic [7:0] av, input logic [7:0] bv,
                      input int hold, input bit clr_at_done);
    logic [7:0] ep;
    logic fe, zi, one;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    ep  = gf_mul(av, bv);
    fe  = av[7] | bv[7];
    zi  = (av[6:0] == 7'h00) || (bv[6:0] == 7'h00);
    one = (ep == 8'h01) && !fe;
    if (clr_at_done) begin
      m_pass = 0;
      m_fail = 0;
    end else if (one) begin
      if (m_pass < 255) m_pass++;
    end else begin
      if (m_fail < 255) m_fail++;
    end
    exp_q.push_back({ep, one, zi, fe, m_pass[7:0], m_fail[7:0]});
    @(posedge clk); // acceptance edge 0
    #1;
    in_valid = 1'b0;
    a = 8'($urandom_range(0, 255)); // late changes must not matter
    b = 8'($urandom_range(0, 255));
    repeat (6) @(posedge clk);
    #1 chk("latency_edge6", out_valid, 0);
    if (clr_at_done) cnt_clr = 1'b1;
    @(posedge clk);
    #1 chk("latency_edge7", out_valid, 1);
    cnt_clr = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 8'h03;
      b = 8'h03;
      chk("in_ready_hold", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00;
    out_ready = 1'b0; cnt_clr = 1'b0;
    #1;
    // Reset values
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_prod",      prod,      0);
    chk("rst_is_one",    is_one,    0);
    chk("rst_zero_in",   zero_in,   0);
    chk("rst_fmt_err",   fmt_err,   0);
    chk("rst_pass",      pass_cnt,  0);
    chk("rst_fail",      fail_cnt,  0);
    chk("rst_state",     dbg_state, 0);
    do_reset();

    // Pin the model with hand-computed products
    chk("model_1x1",    gf_mul(8'h01, 8'h01), 8'h01);
    chk("model_x_xinv", gf_mul(8'h02, 8'h5F), 8'h01);
    chk("model_x6_x",   gf_mul(8'h40, 8'h02), 8'h3F);
    chk("model_zero",   gf_mul(8'h1B, 8'h00), 8'h00);

    send(8'h01, 8'h01, 0, 0);
    chk("t1_pass", pass_cnt, 8'd1);
    chk("t1_fail", fail_cnt, 8'd0);
    send(8'h02, 8'h5F, 0, 0);
    send(8'h5F, 8'h02, 0, 0);
    send(8'h40, 8'h02, 0, 0);
    chk("t3_fail", fail_cnt, 8'd1);
    send(8'h1B, 8'h00, 0, 0);
    send(8'h81, 8'h01, 0, 0);
    chk("t4_pass", pass_cnt, 8'd3);
    chk("t4_fail", fail_cnt, 8'd3);
    send(8'h35, 8'h6A, 0, 0);

    // Backpressure with stray in_valid: no second capture afterwards
    send(8'h02, 8'h5F, 5, 0);
    repeat (10) @(posedge clk);
    #1 chk("no_second_capture", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);

    // Reset at BUSY step 3
    @(negedge clk);
    in_valid = 1'b1; a = 8'h01; b = 8'h01;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready",  in_ready,  1);
    chk("midrst_pass",      pass_cnt,  0);
    chk("midrst_fail",      fail_cnt,  0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_pass = 0;
    m_fail = 0;
    repeat (10) @(posedge clk);
    #1 chk("midrst_no_result", out_valid, 0);

    // Saturation
    for (int k = 0; k < 260; k++) send(8'h01, 8'h01, 0, 0);
    chk("sat_pass", pass_cnt, 8'd255);
    chk("sat_fail", fail_cnt, 8'd0);

    // Clear on the DONE-entry edge wins
    send(8'h01, 8'h01, 0, 1);
    chk("clr_pass", pass_cnt, 8'd0);
    chk("clr_fail", fail_cnt, 8'd0);

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
